// File: rtl/imem_responder_if.sv
// -----------------------------------------------------------------------------
// imem_responder_if
//   Instruction-fetch bus between a requester (master) and the instruction
//   memory responder (slave).
//
//   imem_req       master -> slave  fetch request, level signal
//   imem_req_addr  master -> slave  fetch byte address
//   imem_data      slave  -> master instruction word, valid while imem_resp=1
//   imem_resp      slave  -> master one-cycle response strobe
//   imem_err       slave  -> master response is for a misaligned/out-of-range
//                                   address
// -----------------------------------------------------------------------------
interface imem_responder_if;

    // Width of the returned instruction word.
    localparam int XLEN_WIDTH = 32;

    logic                  imem_req;
    logic [31:0]           imem_req_addr;
    logic [XLEN_WIDTH-1:0] imem_data;
    logic                  imem_resp;
    logic                  imem_err;

    modport master (
        output imem_req,
        output imem_req_addr,
        input  imem_data,
        input  imem_resp,
        input  imem_err
    );

    modport slave (
        input  imem_req,
        input  imem_req_addr,
        output imem_data,
        output imem_resp,
        output imem_err
    );

endinterface : imem_responder_if

// File: rtl/imem_responder.sv
// -----------------------------------------------------------------------------
// imem_responder
//   Fixed-latency instruction memory model with a preload port. A request
//   accepted in IDLE waits LATENCY+1 edges and is answered with a one-cycle
//   imem_resp strobe. Misaligned or out-of-range addresses return a NOP with
//   imem_err set. All outputs are registered.
//
//   Parameters
//     LATENCY    wait cycles between acceptance and response (0..15)
//     DEPTH      number of 32-bit words in the array (power of two, >= 2)
//     PC_INIT    reset program counter of the attached core
//     BASE_ADDR  byte address mapped to word 0 (defaults to PC_INIT)
//
//   Ports
//     clk         clock, all state updates on the rising edge
//     reset_n     asynchronous active-low reset (deassertion synchronised
//                 externally)
//     imem        fetch bus, slave side
//     load_en     preload write strobe
//     load_addr   preload byte address (bits [1:0] ignored)
//     load_data   preload word
//     busy        FSM is in WAIT or RESP
//     resp_count  responses issued since reset, wraps at 2^32
// -----------------------------------------------------------------------------
module imem_responder #(
    parameter int unsigned LATENCY   = 2,
    parameter int unsigned DEPTH     = 1024,
    parameter logic [31:0] PC_INIT   = 32'h8000_0000,
    parameter logic [31:0] BASE_ADDR = PC_INIT
) (
    input  logic                   clk,
    input  logic                   reset_n,
    imem_responder_if.slave        imem,
    input  logic                   load_en,
    input  logic [31:0]            load_addr,
    input  logic [31:0]            load_data,
    output logic                   busy,
    output logic [31:0]            resp_count
);

    localparam int unsigned IDX_W = $clog2(DEPTH);
    // Byte span of the array; 33 bits so 4*DEPTH never wraps.
    localparam logic [32:0] SPAN  = 33'(DEPTH) << 2;
    localparam logic [31:0] NOP   = 32'h0000_0013;
    localparam logic [3:0]  LAT   = 4'(LATENCY);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_e;

    state_e       state_q, state_d;
    logic [3:0]   cnt_q, cnt_d;
    logic [31:0]  addr_q, addr_d;
    logic [31:0]  data_q, data_d;
    logic         err_q, err_d;
    logic         resp_q, resp_d;
    logic         busy_q, busy_d;
    logic [31:0]  resp_count_q, resp_count_d;
    // Low for the first edge after reset release so that edge never accepts.
    logic         armed_q, armed_d;

    logic [31:0]  mem_q [DEPTH];

    // ---------------------------------------------------------------------
    // Address decode. Unsigned subtraction makes addresses below BASE_ADDR
    // wrap to large offsets, which the range compare then rejects.
    // ---------------------------------------------------------------------
    logic [31:0]      req_off;
    logic             req_oor;
    logic [IDX_W-1:0] req_idx;
    logic [31:0]      load_word_addr;
    logic [31:0]      load_off;
    logic             load_oor;
    logic [IDX_W-1:0] load_idx;
    logic             load_hit;
    logic [31:0]      rd_word;

    assign req_off        = addr_q - BASE_ADDR;
    assign req_oor        = {1'b0, req_off} >= SPAN;
    assign req_idx        = req_off[IDX_W+1:2];

    assign load_word_addr = load_addr & ~32'h3;
    assign load_off       = load_word_addr - BASE_ADDR;
    assign load_oor       = {1'b0, load_off} >= SPAN;
    assign load_idx       = load_off[IDX_W+1:2];

    // A load landing on the captured word in the same edge that leaves WAIT
    // must be visible in the response, so bypass the array read.
    assign load_hit       = load_en && !load_oor && (load_idx == req_idx);
    assign rd_word        = load_hit ? load_data : mem_q[req_idx];

    // ---------------------------------------------------------------------
    // Next-state and registered-output logic
    // ---------------------------------------------------------------------
    always_comb begin
        // NOTE: every signal gets a default before the case so no path leaves
        // one unassigned, which would otherwise infer a latch.
        state_d      = state_q;
        cnt_d        = cnt_q;
        addr_d       = addr_q;
        data_d       = data_q;
        err_d        = err_q;
        resp_d       = 1'b0;
        resp_count_d = resp_count_q;
        armed_d      = 1'b1;

        unique case (state_q)
            IDLE: begin
                // Preload has priority; the request simply waits a cycle.
                if (armed_q && imem.imem_req && !load_en) begin
                    state_d = WAIT;
                    cnt_d   = LAT;
                    addr_d  = imem.imem_req_addr;
                end
            end
            WAIT: begin
                if (cnt_q == 4'd0) begin
                    state_d      = RESP;
                    resp_d       = 1'b1;
                    resp_count_d = resp_count_q + 32'd1;
                    if ((addr_q[1:0] != 2'b00) || req_oor) begin
                        data_d = NOP;
                        err_d  = 1'b1;
                    end else begin
                        data_d = rd_word;
                        err_d  = 1'b0;
                    end
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            RESP: begin
                // Never accept here: the requester moves its address on
                // this edge.
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= IDLE;
            cnt_q        <= 4'd0;
            addr_q       <= 32'd0;
            data_q       <= 32'd0;
            err_q        <= 1'b0;
            resp_q       <= 1'b0;
            busy_q       <= 1'b0;
            resp_count_q <= 32'd0;
            armed_q      <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples the
            // pre-edge values, independent of statement order.
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            addr_q       <= addr_d;
            data_q       <= data_d;
            err_q        <= err_d;
            resp_q       <= resp_d;
            busy_q       <= busy_d;
            resp_count_q <= resp_count_d;
            armed_q      <= armed_d;
        end
    end

    // NOTE: the array has no reset; contents survive reset_n and it maps to
    // plain memory rather than thousands of resettable flops.
    always_ff @(posedge clk) begin
        if (load_en && !load_oor) begin
            mem_q[load_idx] <= load_data;
        end
    end

    assign imem.imem_resp = resp_q;
    assign imem.imem_data = data_q;
    assign imem.imem_err  = err_q;
    assign busy           = busy_q;
    assign resp_count     = resp_count_q;

endmodule : imem_responder

// File: tb/tb_imem_responder.sv
// -----------------------------------------------------------------------------
// tb_imem_responder
//   Two responders share clock, reset and the preload port: dut_a with
//   LATENCY=2 for directed and randomized requests, dut_b with LATENCY=0 for a
//   back-to-back stream with imem_req held high. The stimulus pushes the
//   expected response (data, err, due cycle) into a per-DUT queue; a monitor
//   pops and compares whenever imem_resp is seen.
// -----------------------------------------------------------------------------
module tb_imem_responder;

    localparam int          DEPTH = 64;
    localparam logic [31:0] BASE  = 32'h8000_0000;
    localparam int          LAT_A = 2;
    localparam int          LAT_B = 0;
    localparam logic [31:0] NOP   = 32'h0000_0013;

    typedef struct {
        logic [31:0] data;
        logic        err;
        int          due;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        load_en;
    logic [31:0] load_addr;
    logic [31:0] load_data;
    logic        busy_a, busy_b;
    logic [31:0] cnt_a, cnt_b;

    always #5 clk = ~clk;

    imem_responder_if bus_a ();
    imem_responder_if bus_b ();

    imem_responder #(.LATENCY(LAT_A), .DEPTH(DEPTH), .BASE_ADDR(BASE)) u_dut_a (
        .clk        (clk),
        .reset_n    (reset_n),
        .imem       (bus_a),
        .load_en    (load_en),
        .load_addr  (load_addr),
        .load_data  (load_data),
        .busy       (busy_a),
        .resp_count (cnt_a)
    );

    imem_responder #(.LATENCY(LAT_B), .DEPTH(DEPTH), .BASE_ADDR(BASE)) u_dut_b (
        .clk        (clk),
        .reset_n    (reset_n),
        .imem       (bus_b),
        .load_en    (load_en),
        .load_addr  (load_addr),
        .load_data  (load_data),
        .busy       (busy_b),
        .resp_count (cnt_b)
    );

    // Sampled views indexed by DUT id (0 = a, 1 = b).
    logic [1:0]  resp_s, err_s, busy_s;
    logic [31:0] data_s [2];
    logic [31:0] cnt_s  [2];
    assign resp_s    = {bus_b.imem_resp, bus_a.imem_resp};
    assign err_s     = {bus_b.imem_err,  bus_a.imem_err};
    assign busy_s    = {busy_b, busy_a};
    assign data_s[0] = bus_a.imem_data;
    assign data_s[1] = bus_b.imem_data;
    assign cnt_s[0]  = cnt_a;
    assign cnt_s[1]  = cnt_b;

    int          checks   = 0;
    int          failures = 0;
    int          cyc      = 0;
    logic [31:0] ref_mem [DEPTH];
    exp_t        sb_a [$];
    exp_t        sb_b [$];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic exp_t expect_for(input logic [31:0] addr, input int due);
        logic [31:0] off;
        exp_t        e;
        off   = addr - BASE;
        e.due = due;
        if (addr[1:0] != 2'b00 || off >= 32'(4 * DEPTH)) begin
            e.data = NOP;
            e.err  = 1'b1;
        end else begin
            e.data = ref_mem[int'(off >> 2)];
            e.err  = 1'b0;
        end
        return e;
    endfunction

    task automatic model_load(input logic [31:0] addr, input logic [31:0] data);
        logic [31:0] off;
        off = {addr[31:2], 2'b00} - BASE;
        if (off < 32'(4 * DEPTH)) ref_mem[int'(off >> 2)] = data;
    endtask

    task automatic sb_push(input int id, input exp_t e);
        if (id == 0) sb_a.push_back(e);
        else         sb_b.push_back(e);
    endtask

    // ---------------- monitor ----------------
    logic [32:0] last_val [2];
    logic [31:0] n_resp   [2];
    logic        cnt_pend [2];

    task automatic mon(input int id);
        exp_t e;
        int   sz;
        if (!reset_n) begin
            last_val[id] = 33'd0;
            n_resp[id]   = 32'd0;
            cnt_pend[id] = 1'b0;
            return;
        end
        if (cnt_pend[id]) begin
            check($sformatf("resp_count[%0d]", id), 64'(cnt_s[id]), 64'(n_resp[id]));
            cnt_pend[id] = 1'b0;
        end
        if (resp_s[id]) begin
            sz = (id == 0) ? sb_a.size() : sb_b.size();
            if (sz == 0) begin
                check($sformatf("unexpected_resp[%0d]", id), 64'(resp_s[id]), 64'd0);
            end else begin
                e = (id == 0) ? sb_a.pop_front() : sb_b.pop_front();
                check($sformatf("data[%0d]", id), 64'(data_s[id]), 64'(e.data));
                check($sformatf("err[%0d]", id), 64'(err_s[id]), 64'(e.err));
                check($sformatf("resp_cycle[%0d]", id), 64'(cyc), 64'(e.due));
                last_val[id] = {e.err, e.data};
                n_resp[id]   = n_resp[id] + 32'd1;
                cnt_pend[id] = 1'b1;
            end
        end else begin
            check($sformatf("hold[%0d]", id), 64'({err_s[id], data_s[id]}), 64'(last_val[id]));
        end
    endtask

    always @(negedge clk) begin
        mon(0);
        mon(1);
    end

    // ---------------- stimulus helpers (called at a negedge) ----------------
    task automatic drive_req(input int id, input logic r, input logic [31:0] a);
        if (id == 0) begin
            bus_a.imem_req      = r;
            bus_a.imem_req_addr = a;
        end else begin
            bus_b.imem_req      = r;
            bus_b.imem_req_addr = a;
        end
    endtask

    task automatic do_load(input logic [31:0] addr, input logic [31:0] data);
        load_en   = 1'b1;
        load_addr = addr;
        load_data = data;
        model_load(addr, data);
        @(negedge clk);
        load_en = 1'b0;
    endtask

    // Issue one request. delay = edges expected to pass before acceptance;
    // hold = cycles req stays high after acceptance; load_at >= 0 rewrites the
    // captured word in that WAIT cycle. Returns at the response negedge.
    task automatic issue(input int id, input logic [31:0] addr, input int hold,
                         input int load_at, input int delay);
        int          lat;
        int          acc;
        logic [31:0] nd;
        lat = (id == 0) ? LAT_A : LAT_B;
        drive_req(id, 1'b1, addr);
        acc = cyc + 1 + delay;
        if (load_at < 0) sb_push(id, expect_for(addr, acc + lat + 1));
        for (int k = -delay; k <= lat + 1; k++) begin
            @(negedge clk);
            load_en = 1'b0;
            if (k == 0)       check($sformatf("busy_wait[%0d]", id), 64'(busy_s[id]), 64'd1);
            if (k == lat + 1) check($sformatf("busy_resp[%0d]", id), 64'(busy_s[id]), 64'd1);
            if (k >= 0 && k == hold - 1) drive_req(id, 1'b0, addr);
            if (k >= 0 && k == load_at) begin
                nd        = $urandom;
                load_en   = 1'b1;
                load_addr = addr ^ 32'($urandom_range(0, 3));
                load_data = nd;
                model_load(load_addr, nd);
                sb_push(id, expect_for(addr, acc + lat + 1));
            end
        end
        drive_req(id, 1'b0, addr);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        logic [31:0] addr;
        logic [31:0] nd;
        int          acc;
        int          r;
        int          wait_cnt;

        reset_n   = 1'b0;
        load_en   = 1'b0;
        load_addr = 32'd0;
        load_data = 32'd0;
        drive_req(0, 1'b0, 32'd0);
        drive_req(1, 1'b0, 32'd0);

        #12;
        for (int i = 0; i < 2; i++) begin
            check($sformatf("rst_resp[%0d]", i), 64'(resp_s[i]), 64'd0);
            check($sformatf("rst_data[%0d]", i), 64'(data_s[i]), 64'd0);
            check($sformatf("rst_err[%0d]", i),  64'(err_s[i]),  64'd0);
            check($sformatf("rst_busy[%0d]", i), 64'(busy_s[i]), 64'd0);
            check($sformatf("rst_cnt[%0d]", i),  64'(cnt_s[i]),  64'd0);
        end

        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);

        // Preload: word0 is addi x1,x0,5, the rest random.
        for (int i = 0; i < DEPTH; i++) begin
            do_load(BASE + 32'(4 * i), (i == 0) ? 32'h0050_0093 : $urandom);
        end
        // Out-of-range loads are discarded (the first aliases word0 if truncated).
        do_load(BASE + 32'(4 * DEPTH), 32'hDEAD_0001);
        do_load(BASE - 32'd4, 32'hDEAD_0002);
        // Misaligned load address writes word 5.
        do_load(BASE + 32'd23, 32'h1234_5678);

        // Basic fetch of word 0 with req held until the response.
        issue(0, BASE, LAT_A + 2, -1, 0);
        @(negedge clk);
        check("busy_idle", 64'(busy_a), 64'd0);
        issue(0, BASE + 32'd20, LAT_A + 2, -1, 0);

        // Error cases: misaligned, one past the end, below base.
        @(negedge clk); issue(0, BASE + 32'd2, 1, -1, 0);
        @(negedge clk); issue(0, BASE + 32'(4 * DEPTH), 1, -1, 0);
        @(negedge clk); issue(0, BASE - 32'd4, 1, -1, 0);

        // Request dropped one cycle after acceptance.
        @(negedge clk); issue(0, BASE + 32'd12, 1, -1, 0);

        // Load and request together in IDLE: load wins, acceptance slips.
        @(negedge clk);
        nd = 32'hCAFE_0013;
        load_en   = 1'b1;
        load_addr = BASE + 32'd32;
        load_data = nd;
        model_load(BASE + 32'd32, nd);
        issue(0, BASE + 32'd32, LAT_A + 2, -1, 1);

        // Loads to the captured word in the first and last WAIT cycles.
        @(negedge clk); issue(0, BASE + 32'd40, 1, 0, 0);
        @(negedge clk); issue(0, BASE + 32'd44, 1, LAT_A, 0);

        // Back-to-back stream on the zero-latency responder, req held high.
        @(negedge clk);
        drive_req(1, 1'b1, BASE);
        acc = cyc + 1;
        sb_push(1, expect_for(BASE, acc + LAT_B + 1));
        for (int n = 1; n < 8; n++) begin
            repeat ((n == 1) ? 2 : 3) @(negedge clk);
            addr = BASE + 32'(4 * n);
            drive_req(1, 1'b1, addr);
            acc = acc + LAT_B + 3;
            sb_push(1, expect_for(addr, acc + LAT_B + 1));
        end
        repeat (2) @(negedge clk);
        drive_req(1, 1'b0, 32'd0);

        // Randomized requests on dut_a.
        for (int n = 0; n < 30; n++) begin
            r = $urandom_range(0, 9);
            case (r)
                0:       addr = BASE + 32'(4 * $urandom_range(0, DEPTH - 1)) + 32'($urandom_range(1, 3));
                1:       addr = BASE + 32'(4 * DEPTH) + 32'(4 * $urandom_range(0, 15));
                2:       addr = BASE - 32'(4 * $urandom_range(1, 8));
                default: addr = BASE + 32'(4 * $urandom_range(0, DEPTH - 1));
            endcase
            repeat ($urandom_range(1, 2)) @(negedge clk);
            issue(0, addr, $urandom_range(1, LAT_A + 2),
                  ($urandom_range(0, 3) == 0) ? $urandom_range(0, LAT_A) : -1, 0);
        end

        // Reset in the middle of WAIT: outputs clear at once, request is lost.
        @(negedge clk);
        drive_req(0, 1'b1, BASE);
        @(negedge clk);
        drive_req(0, 1'b0, BASE);
        #2 reset_n = 1'b0;
        #1;
        check("midrst_resp", 64'(bus_a.imem_resp), 64'd0);
        check("midrst_data", 64'(bus_a.imem_data), 64'd0);
        check("midrst_err",  64'(bus_a.imem_err),  64'd0);
        check("midrst_busy", 64'(busy_a), 64'd0);
        check("midrst_cnt",  64'(cnt_a),  64'd0);
        sb_a.delete();
        sb_b.delete();
        repeat (3) @(negedge clk);
        // Release with req already high: the first edge must not accept.
        drive_req(0, 1'b1, BASE);
        reset_n = 1'b1;
        issue(0, BASE, LAT_A + 2, -1, 1);

        // Drain both scoreboards within a bounded number of cycles.
        wait_cnt = 0;
        while ((sb_a.size() != 0 || sb_b.size() != 0) && wait_cnt < 20) begin
            @(negedge clk);
            wait_cnt++;
        end
        check("drain_a", 64'(sb_a.size()), 64'd0);
        check("drain_b", 64'(sb_b.size()), 64'd0);
        repeat (3) @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_imem_responder

// File: doc/imem_responder.md
IMEM_RESPONDER -- requirements
Module: imem_responder

Interface
REQ-001 SHALL have parameter LATENCY, default 2, meaning wait cycles between request acceptance and response (legal 0..15).
REQ-002 SHALL have parameter DEPTH, default 1024, meaning the number of 32-bit words in the instruction array (power of two).
REQ-003 SHALL have parameter BASE_ADDR, default PC_INIT, meaning the byte address that maps to word 0.
REQ-004 SHALL have port clk  in  1  meaning the single clock; all state is updated on its rising edge.
REQ-005 SHALL have port reset_n  in  1  meaning asynchronous active-low reset.
REQ-006 SHALL have port imem_req  in  1  meaning fetch request, a level signal.
REQ-007 SHALL have port imem_req_addr  in  32  meaning fetch byte address.
REQ-008 SHALL have port imem_data  out  XLEN_WIDTH  meaning instruction word.
REQ-009 SHALL have port imem_resp  out  1  meaning a one-cycle response strobe.
REQ-010 SHALL have port imem_err  out  1  meaning the response is for a misaligned or out-of-range address.
REQ-011 SHALL have port load_en  in  1  meaning a preload write strobe.
REQ-012 SHALL have port load_addr  in  32  meaning the preload byte address.
REQ-013 SHALL have port load_data  in  32  meaning the preload word.
REQ-014 SHALL have port busy  out  1  meaning the FSM is not in IDLE.
REQ-015 SHALL have port resp_count  out  32  meaning the number of responses issued since reset.

Function
REQ-016 SHALL implement FSM states IDLE, WAIT and RESP, with all outputs registered.
REQ-017 SHALL, in IDLE, accept a request at an edge where imem_req=1 and load_en=0, capture imem_req_addr, and go to WAIT with the counter set to LATENCY.
REQ-018 SHALL, in WAIT, decrement the counter each edge and go to RESP when the counter is 0 (LATENCY=0 means WAIT lasts one cycle).
REQ-019 SHALL hold imem_resp=1 for exactly the single cycle spent in RESP, with imem_data and imem_err valid in that cycle.
REQ-020 SHALL give a response latency of LATENCY+1 cycles from the acceptance edge to the cycle in which imem_resp is high.
REQ-021 SHALL always return from RESP to IDLE, so that no request is accepted at the RESP edge (the requester updates its address at that edge); maximum throughput is one response per LATENCY+3 cycles.
REQ-022 SHALL complete an accepted request even if imem_req falls during WAIT; requests are non-abortable and always return data for the captured address.
REQ-023 SHALL compute the word index as ((addr - BASE_ADDR) >> 2) truncated to log2(DEPTH) bits.
REQ-024 SHALL define a request address as out of range when (addr - BASE_ADDR) >= 4*DEPTH, using unsigned 32-bit arithmetic so that addresses below BASE_ADDR wrap and count as out of range.
REQ-025 SHALL, when addr[1:0] != 0 or the address is out of range, return imem_data=32'h00000013 (NOP) and imem_err=1; otherwise it SHALL return the array word and imem_err=0.
REQ-026 SHALL hold imem_data and imem_err at their last values outside RESP.
REQ-027 SHALL write load_data to the array at the edge where load_en=1, ignoring load_addr[1:0], and discard out-of-range load writes.
REQ-028 SHALL give load_en priority over acceptance in IDLE (the request waits); a load_en during WAIT or RESP SHALL still write.
REQ-029 SHALL, when a load in WAIT targets the captured word, return the newly written data.
REQ-030 SHALL increment resp_count on each RESP cycle, wrapping from 2^32-1 to 0.
REQ-031 SHALL drive busy=1 in WAIT and RESP.

Reset
REQ-032 SHALL, on reset_n=0, immediately and asynchronously force: state IDLE, imem_resp=0, imem_data=0, imem_err=0, busy=0, resp_count=0, counter=0.
REQ-033 SHALL abandon any in-flight request on reset with no response issued; the array contents are not reset.
REQ-034 SHALL synchronise deassertion of reset_n externally; the block accepts no request on the first edge after release.

Verification
REQ-035 SHALL cover: LATENCY=2, preload word0=32'h00500093, request addr=BASE_ADDR held high -> imem_resp high for one cycle 3 cycles after acceptance, data=32'h00500093, err=0, resp_count=1.
REQ-036 SHALL cover: LATENCY=0, imem_req held high continuously, addresses +4 per response -> one response per 3 cycles with correct sequential words.
REQ-037 SHALL cover: request addr=BASE_ADDR+2 -> data=32'h00000013, err=1; request addr=BASE_ADDR+4*DEPTH -> NOP with err=1; request addr=BASE_ADDR-4 -> NOP with err=1.
REQ-038 SHALL cover: imem_req dropped one cycle after acceptance -> response still issued for the captured address.
REQ-039 SHALL cover: load_en and imem_req together in IDLE -> write occurs, acceptance delayed one cycle; a load to the captured word during WAIT -> new data returned.
REQ-040 SHALL cover: reset_n asserted mid-WAIT -> outputs zero immediately, no imem_resp afterwards, array contents intact for the next request.
